// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Brief    : AES-128 constants and byte/word transform functions.
// Revision : 1.0
// ============================================================================
package aes_pkg;

    localparam int NR128 = 10;

    // Forward S-box, byte 0 is the left-most entry.
    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] subBytes(input logic [127:0] s);
        return {subWord(s[127:96]), subWord(s[95:64]), subWord(s[63:32]), subWord(s[31:0])};
    endfunction

    // State bytes are column-major: byte 4*c+r sits at bits [127-8*(4c+r) -: 8].
    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] keyExpand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = subWord({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_round
// Brief    : One combinational AES-128 encryption round plus key expansion step.
// Revision : 1.0
// ============================================================================
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_key,
    input  logic [3:0]   i_rnd,
    input  logic         i_last,
    output logic [127:0] o_state,
    output logic [127:0] o_key
);

    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;

    always_comb begin
        o_key   = keyExpand(i_key, rcon(i_rnd));
        w_sb    = subBytes(i_state);
        w_sr    = shiftRows(w_sb);
        w_mc    = mixColumns(w_sr);
        // Final round skips MixColumns.
        o_state = (i_last ? w_sr : w_mc) ^ o_key;
    end

endmodule
`default_nettype wire

// File: rtl/aes_ring_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_ring_core
// Brief    : Self-sequenced AES-128 engine keeping NCTX blocks in a slot ring.
// Revision : 1.0
// ============================================================================
module aes_ring_core
    import aes_pkg::*;
#(
    parameter int NCTX = 4,
    parameter int NR   = NR128,
    parameter int TAGW = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [127:0]                in_text,
    input  logic [127:0]                in_key,
    input  logic [TAGW-1:0]             in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [127:0]                out_text,
    output logic [TAGW-1:0]             out_tag,
    output logic [$clog2(NCTX+1)-1:0]   occupancy,
    output logic                        busy
);

    localparam int c_OCCW = $clog2(NCTX + 1);

    typedef struct packed {
        logic            valid;
        logic            done;
        logic [3:0]      rnd;
        logic [127:0]    state;
        logic [127:0]    key;
        logic [TAGW-1:0] tag;
    } slot_t;

    slot_t              r_ring [NCTX];
    slot_t              w_head;
    slot_t              w_next;
    logic               w_last;
    logic               w_outValid;
    logic               w_retire;
    logic               w_stall;
    logic               w_inReady;
    logic               w_insert;
    logic [127:0]       w_rndState;
    logic [127:0]       w_rndKey;
    logic [c_OCCW-1:0]  r_occ;
    logic [c_OCCW-1:0]  w_occNext;
    logic               r_busy;

    assign w_head     = r_ring[NCTX-1];
    assign w_last     = (w_head.rnd == 4'(NR));
    assign w_outValid = w_head.valid && w_head.done;
    assign w_retire   = w_outValid && out_ready;
    assign w_stall    = w_outValid && !out_ready;
    // The head slot is free for a new block when empty or retiring this cycle.
    assign w_inReady  = !w_head.valid || w_retire;
    assign w_insert   = in_valid && w_inReady;

    aes_round u_round (
        .i_state (w_head.state),
        .i_key   (w_head.key),
        .i_rnd   (w_head.rnd),
        .i_last  (w_last),
        .o_state (w_rndState),
        .o_key   (w_rndKey)
    );

    always_comb begin
        w_next = '0;
        if (w_head.valid && !w_head.done) begin
            w_next.valid = 1'b1;
            w_next.done  = w_last;
            w_next.rnd   = w_head.rnd + 4'd1;
            w_next.state = w_rndState;
            w_next.key   = w_rndKey;
            w_next.tag   = w_head.tag;
        end else if (w_insert) begin
            w_next.valid = 1'b1;
            w_next.done  = 1'b0;
            w_next.rnd   = 4'd1;
            w_next.state = in_text ^ in_key;
            w_next.key   = in_key;
            w_next.tag   = in_tag;
        end
    end

    always_comb begin
        w_occNext = r_occ;
        if (w_insert && !w_retire) begin
            w_occNext = r_occ + c_OCCW'(1);
        end else if (w_retire && !w_insert) begin
            w_occNext = r_occ - c_OCCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCTX; i++) begin
                r_ring[i] <= '0;
            end
            r_occ  <= '0;
            r_busy <= 1'b0;
        end else begin
            // A finished head waiting on the consumer freezes the whole ring.
            if (!w_stall) begin
                for (int i = NCTX - 1; i > 0; i--) begin
                    r_ring[i] <= r_ring[i-1];
                end
                r_ring[0] <= w_next;
            end
            r_occ  <= w_occNext;
            r_busy <= (w_occNext != '0);
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = w_outValid;
    assign out_text  = w_outValid ? w_head.state : '0;
    assign out_tag   = w_outValid ? w_head.tag : '0;
    assign occupancy = r_occ;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_ring_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aes_ring_core
// Brief    : Directed bench for aes_ring_core with a queue-based timing model.
// Revision : 1.0
// ============================================================================
module tb_aes_ring_core;

    localparam int NCTX = 4;
    localparam int NR   = 10;
    localparam int TAGW = 4;
    localparam int LAT  = (NR + 1) * NCTX;

    localparam logic [127:0] c_PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            inValid = 1'b0;
    logic            outReady = 1'b1;
    logic [127:0]    inText = '0;
    logic [127:0]    inKey = '0;
    logic [TAGW-1:0] inTag = '0;
    logic            inReady, outValid, busy;
    logic [127:0]    outText;
    logic [TAGW-1:0] outTag;
    logic [2:0]      occupancy;

    logic            inValid1 = 1'b0;
    logic            outReady1 = 1'b1;
    logic [127:0]    inText1 = '0;
    logic [127:0]    inKey1 = '0;
    logic [TAGW-1:0] inTag1 = '0;
    logic            inReady1, outValid1, busy1;
    logic [127:0]    outText1;
    logic [TAGW-1:0] outTag1;
    logic [0:0]      occupancy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    aes_ring_core #(.NCTX(NCTX), .NR(NR), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady), .in_text(inText), .in_key(inKey), .in_tag(inTag),
        .out_valid(outValid), .out_ready(outReady), .out_text(outText), .out_tag(outTag),
        .occupancy(occupancy), .busy(busy)
    );

    aes_ring_core #(.NCTX(1), .NR(NR), .TAGW(TAGW)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(inValid1), .in_ready(inReady1), .in_text(inText1), .in_key(inKey1), .in_tag(inTag1),
        .out_valid(outValid1), .out_ready(outReady1), .out_text(outText1), .out_tag(outTag1),
        .occupancy(occupancy1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] refCipher(input logic [127:0] pt, input logic [127:0] key);
        if (pt == c_PT_B && key == c_KEY_B)   return c_CT_B;
        if (pt == c_PT_C1 && key == c_KEY_C1) return c_CT_C1;
        return '0;
    endfunction

    // Model: each block ages once per non-stalled cycle; it occupies the head
    // whenever its age is a multiple of NCTX and is finished at age LAT.
    typedef struct {
        logic [127:0]    ct;
        logic [TAGW-1:0] tag;
        int              age;
    } ent_t;

    typedef struct {
        int              cyc;
        logic [127:0]    text;
        logic [TAGW-1:0] tag;
    } ev_t;

    ent_t mq[$];
    ev_t  evLog[$];

    always @(negedge clk) begin : p_model
        logic            expOv, headOcc, expIr;
        logic [127:0]    expText;
        logic [TAGW-1:0] expTag;
        ent_t            e;
        ev_t             ev;
        if (rst) begin
            mq.delete();
            chk("rst_out_valid", outValid, 0);
            chk("rst_out_text", outText, 0);
            chk("rst_occupancy", occupancy, 0);
            chk("rst_busy", busy, 0);
        end else begin
            expOv   = (mq.size() != 0) && (mq[0].age == LAT);
            expText = '0;
            expTag  = '0;
            if (expOv) begin
                expText = mq[0].ct;
                expTag  = mq[0].tag;
            end
            headOcc = 1'b0;
            foreach (mq[i]) if (mq[i].age % NCTX == 0) headOcc = 1'b1;
            expIr = !headOcc || (expOv && outReady);
            chk("out_valid", outValid, expOv);
            chk("out_text", outText, expText);
            chk("out_tag", outTag, expTag);
            chk("in_ready", inReady, expIr);
            chk("occupancy", occupancy, mq.size());
            chk("busy", busy, mq.size() != 0);
            if (outValid && outReady) begin
                ev.cyc = cyc; ev.text = outText; ev.tag = outTag;
                evLog.push_back(ev);
            end
            if (!(expOv && !outReady)) begin
                if (expOv) void'(mq.pop_front());
                foreach (mq[i]) mq[i].age = mq[i].age + 1;
                if (inValid && expIr) begin
                    e.ct = refCipher(inText, inKey); e.tag = inTag; e.age = 1;
                    mq.push_back(e);
                end
            end
        end
    end

    // Call between a rising edge and the next falling edge; returns just after
    // the accepting edge with in_valid dropped.
    task automatic send(input logic [127:0] pt, input logic [127:0] key,
                        input logic [TAGW-1:0] tag, output int acc);
        logic got;
        got = 1'b0;
        acc = -1;
        inValid = 1'b1; inText = pt; inKey = key; inTag = tag;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (inReady) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no in_ready, expected acceptance of tag %0d", tag);
        end
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic waitLog(input int n, input int limit);
        for (int k = 0; k < limit && evLog.size() < n; k++) @(posedge clk);
        if (evLog.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_output: got %0d outputs, expected %0d", evLog.size(), n);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of stimulus");
        $fatal(1);
    end

    initial begin : p_stim
        int c0, c5, dmy, t0, cnt;
        t0 = 0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_occupancy", occupancy, 0);
        chk("reset_out_valid", outValid, 0);
        rst = 1'b0;
        #1 chk("ready_after_reset", inReady, 1);

        // Single block.
        evLog.delete();
        send(c_PT_B, c_KEY_B, 4'd3, c0);
        repeat (2) @(negedge clk);
        chk("t1_occ_flight", occupancy, 1);
        chk("t1_busy_flight", busy, 1);
        waitLog(1, 100);
        if (evLog.size() >= 1) begin
            chk("t1_latency", evLog[0].cyc - c0, 44);
            chk("t1_text", evLog[0].text, c_CT_B);
            chk("t1_tag", evLog[0].tag, 3);
        end
        @(negedge clk);
        chk("t1_occ_after", occupancy, 0);
        chk("t1_busy_after", busy, 0);

        // Four back-to-back blocks.
        @(posedge clk); #1;
        evLog.delete();
        send(c_PT_B, c_KEY_B, 4'd0, c0);
        send(c_PT_C1, c_KEY_C1, 4'd1, dmy);
        send(c_PT_B, c_KEY_B, 4'd2, dmy);
        send(c_PT_C1, c_KEY_C1, 4'd3, dmy);
        @(negedge clk);
        chk("t2_ready_low", inReady, 0);
        chk("t2_occ_full", occupancy, 4);
        waitLog(4, 100);
        for (int k = 0; k < 4 && k < evLog.size(); k++) begin
            chk("t2_cycle", evLog[k].cyc - c0, 44 + k);
            chk("t2_tag", evLog[k].tag, k);
            chk("t2_text", evLog[k].text, (k % 2 == 0) ? c_CT_B : c_CT_C1);
        end

        // Backpressure on the first finished block for 7 cycles.
        evLog.delete();
        send(c_PT_B, c_KEY_B, 4'd8, c0);
        send(c_PT_C1, c_KEY_C1, 4'd9, dmy);
        send(c_PT_B, c_KEY_B, 4'd10, dmy);
        send(c_PT_C1, c_KEY_C1, 4'd11, dmy);
        outReady = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100 && cnt == 0; k++) begin
            @(negedge clk);
            if (outValid) begin cnt = 1; t0 = cyc; end
        end
        chk("t3_first_valid", t0 - c0, 44);
        for (int j = 1; j < 7; j++) begin
            @(negedge clk);
            chk("t3_stall_valid", outValid, 1);
            chk("t3_stall_text", outText, c_CT_B);
            chk("t3_stall_tag", outTag, 8);
            chk("t3_stall_ready", inReady, 0);
        end
        @(posedge clk); #1;
        outReady = 1'b1;
        waitLog(4, 100);
        for (int k = 0; k < 4 && k < evLog.size(); k++) begin
            chk("t3_cycle", evLog[k].cyc - c0, 51 + k);
            chk("t3_tag", evLog[k].tag, 8 + k);
        end

        // Retire and insert in the same cycle on a full ring.
        evLog.delete();
        send(c_PT_B, c_KEY_B, 4'd12, c0);
        send(c_PT_C1, c_KEY_C1, 4'd13, dmy);
        send(c_PT_B, c_KEY_B, 4'd14, dmy);
        send(c_PT_C1, c_KEY_C1, 4'd15, dmy);
        send(c_PT_C1, c_KEY_C1, 4'd5, c5);
        chk("t4_accept_cycle", c5 - c0, 44);
        chk("t4_occ_kept", occupancy, 4);
        waitLog(5, 120);
        if (evLog.size() >= 5) begin
            chk("t4_first_cycle", evLog[0].cyc - c0, 44);
            chk("t4_new_latency", evLog[4].cyc - c5, 44);
            chk("t4_new_tag", evLog[4].tag, 5);
            chk("t4_new_text", evLog[4].text, c_CT_C1);
        end

        // Asynchronous reset with three blocks in flight.
        send(c_PT_B, c_KEY_B, 4'd1, dmy);
        send(c_PT_C1, c_KEY_C1, 4'd2, dmy);
        send(c_PT_B, c_KEY_B, 4'd3, dmy);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_occ_cleared", occupancy, 0);
        chk("t5_busy_cleared", busy, 0);
        chk("t5_valid_cleared", outValid, 0);
        chk("t5_text_cleared", outText, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("t5_ready_release", inReady, 1);
        evLog.delete();
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (outValid) cnt++;
        end
        chk("t5_no_output", cnt, 0);

        // Single-slot ring: second block only enters in the first one's retire cycle.
        @(posedge clk); #1;
        inValid1 = 1'b1; inText1 = c_PT_C1; inKey1 = c_KEY_C1; inTag1 = 4'd1;
        @(negedge clk);
        chk("t6_ready_first", inReady1, 1);
        @(posedge clk); #1;
        inText1 = c_PT_B; inKey1 = c_KEY_B; inTag1 = 4'd2;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k < 11) begin
                chk("t6_wait_ready", inReady1, 0);
                chk("t6_wait_valid", outValid1, 0);
                if (k == 5) chk("t6_occ", occupancy1, 1);
            end else if (k == 11) begin
                chk("t6_first_valid", outValid1, 1);
                chk("t6_first_text", outText1, c_CT_C1);
                chk("t6_first_tag", outTag1, 1);
                chk("t6_retire_ready", inReady1, 1);
                @(posedge clk); #1;
                inValid1 = 1'b0;
            end else if (k < 22) begin
                chk("t6_gap_valid", outValid1, 0);
            end else begin
                chk("t6_second_valid", outValid1, 1);
                chk("t6_second_text", outText1, c_CT_B);
                chk("t6_second_tag", outTag1, 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
